// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder/subtractor.
package addsub_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_BLOCK = 8;

  // Number of lookahead groups, which is also the number of compute stages.
  function automatic int calc_ngrp(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/pipelined_cla_addsub_cla_group.sv
// BLOCK-bit carry-lookahead group: sum bits, group generate/propagate and the
// carry into its top bit (needed for the signed-overflow flag).
module cla_group #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             g,
  output logic             p,
  output logic             c_top
);

  logic [BLOCK-1:0] gen;
  logic [BLOCK-1:0] prop;
  logic [BLOCK-1:0] carry;

  // Flattened sum-of-products carry into bit n: no ripple through lower bits.
  function automatic logic la_carry(input logic [BLOCK-1:0] gv, input logic [BLOCK-1:0] pv,
                                    input logic c0, input int n);
    logic res;
    logic term;
    res = c0;
    for (int k = 0; k < BLOCK; k++)
      if (k < n) res = res & pv[k];
    for (int j = 0; j < BLOCK; j++) begin
      if (j < n) begin
        term = gv[j];
        for (int k = 0; k < BLOCK; k++)
          if (k > j && k < n) term = term & pv[k];
        res = res | term;
      end
    end
    return res;
  endfunction

  assign gen  = a & b;
  assign prop = a ^ b;

  for (genvar gi = 0; gi < BLOCK; gi++) begin : g_carry
    assign carry[gi] = la_carry(gen, prop, cin, gi);
  end

  assign s     = prop ^ carry;
  assign g     = la_carry(gen, prop, 1'b0, BLOCK);
  assign p     = &prop;
  assign c_top = carry[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined WIDTH-bit add/sub: one lookahead group per stage, operands skewed
// through the pipe, global stall on output backpressure.
module pipelined_cla_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = calc_ngrp(WIDTH, BLOCK);

  if (WIDTH % BLOCK != 0 || WIDTH < BLOCK) begin : g_bad_params
    $error("pipelined_cla_addsub: WIDTH must be a positive multiple of BLOCK");
  end

  // Index k of the operand/carry registers feeds group k; index 0 is the
  // operand capture stage, so group 0 never sits behind the input pins.
  logic [NGRP:0]                valid_reg;
  logic [NGRP-1:0][WIDTH-1:0]   a_reg;
  logic [NGRP-1:0][WIDTH-1:0]   b_reg;
  logic [NGRP:0]                carry_reg;
  logic [NGRP:1][WIDTH-1:0]     sum_reg;
  logic                         ovf_reg;

  logic [NGRP-1:0][BLOCK-1:0]   grp_sum;
  logic [NGRP-1:0]              grp_g;
  logic [NGRP-1:0]              grp_p;
  logic [NGRP-1:0]              grp_ctop;
  logic [NGRP-1:0]              grp_cout;
  logic [NGRP-1:0][WIDTH-1:0]   merged_sum;
  logic                         stall;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_stage
    cla_group #(.BLOCK(BLOCK)) u_group (
      .a     (a_reg[gi][gi*BLOCK +: BLOCK]),
      .b     (b_reg[gi][gi*BLOCK +: BLOCK]),
      .cin   (carry_reg[gi]),
      .s     (grp_sum[gi]),
      .g     (grp_g[gi]),
      .p     (grp_p[gi]),
      .c_top (grp_ctop[gi])
    );

    assign grp_cout[gi] = grp_g[gi] | (grp_p[gi] & carry_reg[gi]);

    // Partial sums only ever hold lower groups, so the new slice can be OR-ed in.
    if (gi == 0) begin : g_first
      assign merged_sum[gi] = WIDTH'(grp_sum[gi]);
    end else begin : g_rest
      assign merged_sum[gi] = sum_reg[gi] | (WIDTH'(grp_sum[gi]) << (gi*BLOCK));
    end
  end

  assign stall = valid_reg[NGRP] && !out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= '0;
      sum_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else if (!stall) begin
      valid_reg[0] <= in_valid;
      a_reg[0]     <= a;
      b_reg[0]     <= b ^ {WIDTH{sub}};
      carry_reg[0] <= cin ^ sub;
      for (int k = 0; k < NGRP; k++) begin
        valid_reg[k+1] <= valid_reg[k];
        sum_reg[k+1]   <= merged_sum[k];
        carry_reg[k+1] <= grp_cout[k];
      end
      for (int k = 0; k < NGRP - 1; k++) begin
        a_reg[k+1] <= a_reg[k];
        b_reg[k+1] <= b_reg[k];
      end
      ovf_reg <= grp_ctop[NGRP-1] ^ grp_cout[NGRP-1];
    end
  end

  assign in_ready  = !stall;
  assign out_valid = valid_reg[NGRP];
  assign sum       = sum_reg[NGRP];
  assign cout      = carry_reg[NGRP];
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed and reference-model checks for pipelined_cla_addsub at 32/8, 16/4 and 8/8.
module tb_pipelined_cla_addsub;

  logic        clock;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        sub, cin, cout, ovf;

  logic        r_reset;
  logic [1:0]  r_in_valid, r_in_ready, r_out_valid, r_out_ready;
  logic [1:0]  r_sub, r_cin, r_cout, r_ovf;
  logic [15:0] r_a0, r_b0, r_sum0;
  logic [7:0]  r_a1, r_b1, r_sum1;

  int checks = 0;
  int failures = 0;

  localparam int NRAND = 10000;

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4)) u_dut16 (
    .clock(clock), .reset(r_reset), .in_valid(r_in_valid[0]), .in_ready(r_in_ready[0]),
    .a(r_a0), .b(r_b0), .sub(r_sub[0]), .cin(r_cin[0]), .out_valid(r_out_valid[0]),
    .out_ready(r_out_ready[0]), .sum(r_sum0), .cout(r_cout[0]), .ovf(r_ovf[0])
  );

  pipelined_cla_addsub #(.WIDTH(8), .BLOCK(8)) u_dut8 (
    .clock(clock), .reset(r_reset), .in_valid(r_in_valid[1]), .in_ready(r_in_ready[1]),
    .a(r_a1), .b(r_b1), .sub(r_sub[1]), .cin(r_cin[1]), .out_valid(r_out_valid[1]),
    .out_ready(r_out_ready[1]), .sum(r_sum1), .cout(r_cout[1]), .ovf(r_ovf[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signed overflow from operand/result signs, independent of carry taps.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] ra, input logic [15:0] rb,
                                            input logic rs, input logic rc);
    int unsigned mask, ua, ub, full;
    logic co, ov;
    mask = (32'd1 << w) - 32'd1;
    ua   = {16'h0, ra} & mask;
    ub   = {16'h0, (rs ? ~rb : rb)} & mask;
    full = ua + ub + {31'd0, rc ^ rs};
    co   = full[w];
    ov   = (ua[w-1] == ub[w-1]) && (full[w-1] != ua[w-1]);
    return {ov, co, full[15:0] & mask[15:0]};
  endfunction

  task automatic run_beat(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vsub, input logic vcin,
                          input logic [31:0] esum, input logic ecout, input logic eovf);
    int lat;
    out_ready = 1'b1;
    a = va; b = vb; sub = vsub; cin = vcin; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_lat"},  64'(lat),  64'(4));
    check({tag, "_sum"},  64'(sum),  64'(esum));
    check({tag, "_cout"}, 64'(cout), 64'(ecout));
    check({tag, "_ovf"},  64'(ovf),  64'(eovf));
    @(posedge clock); #1;
    check({tag, "_drain"}, 64'(out_valid), 64'(0));
  endtask

  task automatic stall_test();
    logic [31:0] exp_sum [6];
    int sent, recv, stall_left, extra;
    logic got_first;
    for (int i = 0; i < 6; i++) exp_sum[i] = 32'((i + 1) * 257);
    sent = 0; recv = 0; stall_left = 3; got_first = 1'b0;
    for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
      in_valid  = (sent < 6);
      a         = 32'(sent + 1);
      b         = 32'(sent + 1) << 8;
      sub       = 1'b0;
      cin       = 1'b0;
      out_ready = !(got_first && stall_left > 0);
      #1;
      if (!out_ready) begin
        check("stall_in_ready",  64'(in_ready),  64'(0));
        check("stall_out_valid", 64'(out_valid), 64'(1));
        check("stall_hold_sum",  64'(sum),       64'(exp_sum[recv]));
        stall_left--;
      end
      if (out_valid && out_ready) begin
        check("order_sum", 64'(sum), 64'(exp_sum[recv]));
        recv++;
        got_first = 1'b1;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stall_recv", 64'(recv), 64'(6));
    check("stall_sent", 64'(sent), 64'(6));
    extra = 0;
    repeat (4) begin
      if (out_valid) extra++;
      @(posedge clock); #1;
    end
    check("stall_no_dup", 64'(extra), 64'(0));
  endtask

  task automatic reset_test();
    int stale;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i + 1) << 4; b = 32'h10; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_flush_valid", 64'(out_valid), 64'(0));
    check("rst_flush_ready", 64'(in_ready),  64'(1));
    stale = 0;
    repeat (8) begin
      @(posedge clock); #1;
      if (out_valid) stale++;
    end
    check("rst_no_stale", 64'(stale), 64'(0));
    run_beat("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
  endtask

  task automatic random_test();
    logic [17:0] q0[$], q1[$];
    logic [17:0] exp;
    int acc0, acc1;
    logic took0, took1;
    acc0 = 0; acc1 = 0; took0 = 1'b0; took1 = 1'b0;
    for (int cyc = 0; cyc < 60000 &&
         !(acc0 == NRAND && acc1 == NRAND && q0.size() == 0 && q1.size() == 0); cyc++) begin
      if (took0) r_in_valid[0] = 1'b0;
      if (took1) r_in_valid[1] = 1'b0;
      if (!r_in_valid[0] && acc0 < NRAND && $urandom_range(0, 3) != 0) begin
        r_in_valid[0] = 1'b1; r_a0 = 16'($urandom); r_b0 = 16'($urandom);
        r_sub[0] = 1'($urandom); r_cin[0] = 1'($urandom);
      end
      if (!r_in_valid[1] && acc1 < NRAND && $urandom_range(0, 3) != 0) begin
        r_in_valid[1] = 1'b1; r_a1 = 8'($urandom); r_b1 = 8'($urandom);
        r_sub[1] = 1'($urandom); r_cin[1] = 1'($urandom);
      end
      r_out_ready[0] = ($urandom_range(0, 3) != 0);
      r_out_ready[1] = ($urandom_range(0, 3) != 0);
      #1;
      if (r_out_valid[0] && r_out_ready[0]) begin
        if (q0.size() == 0) check("r16_extra", 64'(1), 64'(0));
        else begin
          exp = q0.pop_front();
          check("r16_beat", 64'({r_ovf[0], r_cout[0], r_sum0}), 64'(exp));
        end
      end
      if (r_out_valid[1] && r_out_ready[1]) begin
        if (q1.size() == 0) check("r8_extra", 64'(1), 64'(0));
        else begin
          exp = q1.pop_front();
          check("r8_beat", 64'({r_ovf[1], r_cout[1], 8'h00, r_sum1}), 64'(exp));
        end
      end
      took0 = r_in_valid[0] && r_in_ready[0];
      took1 = r_in_valid[1] && r_in_ready[1];
      if (took0) begin q0.push_back(ref_model(16, r_a0, r_b0, r_sub[0], r_cin[0])); acc0++; end
      if (took1) begin q1.push_back(ref_model(8, {8'h00, r_a1}, {8'h00, r_b1}, r_sub[1], r_cin[1])); acc1++; end
      @(posedge clock); #1;
    end
    r_in_valid = 2'b00;
    check("r16_done", 64'(acc0 + q0.size()), 64'(NRAND));
    check("r8_done",  64'(acc1 + q1.size()), 64'(NRAND));
    check("r16_drained", 64'(q0.size()), 64'(0));
    check("r8_drained",  64'(q1.size()), 64'(0));
  endtask

  initial begin
    reset = 1'b1; r_reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    r_in_valid = '0; r_out_ready = '0; r_sub = '0; r_cin = '0;
    r_a0 = '0; r_b0 = '0; r_a1 = '0; r_b1 = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; r_reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum",       64'(sum),       64'(0));
    check("rst_cout",      64'(cout),      64'(0));
    check("rst_ovf",       64'(ovf),       64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    fork
      begin
        run_beat("wrap",      32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_beat("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_beat("neg_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_beat("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_beat("sub_borrow",32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_beat("add_cin",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0101, 1'b0, 1'b0);
        run_beat("sub_equal", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        stall_test();
        reset_test();
      end
      random_test();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
